// File: rtl/uart_tx_framer.sv
// UART transmitter with a byte FIFO in front of it. Frames are start, data (LSB first),
// optional parity and 1-2 stop bits. Queued bytes go out back-to-back with no idle gap.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_tx_dv,
  input  logic [7:0]                    i_tx_byte,
  output logic                          o_tx_ready,
  output logic                          o_tx_serial,
  output logic                          o_tx_active,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [7:0]         shift_q, shift_d;
  logic               parity_q, parity_d;
  logic [7:0]         mem [FIFO_DEPTH];

  logic               fifo_empty, fifo_full, push, pop;
  logic [7:0]         head;

  // Parity is taken over the masked data bits only.
  function automatic logic parity_of(input logic [7:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FIFO_FULL);
    push       = i_tx_dv & ~fifo_full;
    head       = mem[rd_ptr_q] & DATA_MASK;
    pop        = 1'b0;

    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    shift_d   = shift_q;
    parity_d  = parity_q;

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          serial_d  = 1'b0;
          active_d  = 1'b1;
          clk_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              serial_d = parity_q;
              state_d  = S_PARITY;
            end else begin
              serial_d = 1'b1;
              state_d  = S_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = 1'b1;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            // A waiting byte starts its frame on the very next clock.
            if (!fifo_empty) begin
              pop      = 1'b1;
              serial_d = 1'b0;
              state_d  = S_START;
            end else begin
              serial_d = 1'b1;
              active_d = 1'b0;
              state_d  = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        serial_d  = 1'b1;
        active_d  = 1'b0;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase

    if (pop) begin
      shift_d  = head;
      parity_d = parity_of(head);
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Datapath storage: only ever read after being written, so no reset.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    parity_q <= parity_d;
    if (push) mem[wr_ptr_q] <= i_tx_byte;
  end

  assign o_tx_ready   = ~fifo_full;
  assign o_tx_serial  = serial_q;
  assign o_tx_active  = active_q;
  assign o_tx_done    = done_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four instances (8N1 depth 4, 8E1, 8O1, 7N2) at 4 clocks/bit.
module tb_uart_tx_framer;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [3:0] dv  = 4'b0;
  logic [7:0] by [4];
  logic [3:0] ser, act, dn, rdy;
  logic [2:0] cnt0;
  logic [4:0] cnt1, cnt2, cnt3;

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .i_tx_dv(dv[0]), .i_tx_byte(by[0]), .o_tx_ready(rdy[0]),
    .o_tx_serial(ser[0]), .o_tx_active(act[0]), .o_tx_done(dn[0]), .o_fifo_count(cnt0));
  uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY(2)) u1 (
    .clk(clk), .rst(rst), .i_tx_dv(dv[1]), .i_tx_byte(by[1]), .o_tx_ready(rdy[1]),
    .o_tx_serial(ser[1]), .o_tx_active(act[1]), .o_tx_done(dn[1]), .o_fifo_count(cnt1));
  uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY(1)) u2 (
    .clk(clk), .rst(rst), .i_tx_dv(dv[2]), .i_tx_byte(by[2]), .o_tx_ready(rdy[2]),
    .o_tx_serial(ser[2]), .o_tx_active(act[2]), .o_tx_done(dn[2]), .o_fifo_count(cnt2));
  uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .i_tx_dv(dv[3]), .i_tx_byte(by[3]), .o_tx_ready(rdy[3]),
    .o_tx_serial(ser[3]), .o_tx_active(act[3]), .o_tx_done(dn[3]), .o_fifo_count(cnt3));

  int n_cmp = 0;
  int n_bad = 0;

  // Sample k is the DUT state just after rising edge k.
  int         ncyc = 0;
  logic [3:0] ser_r [0:4095];
  logic [3:0] dn_r  [0:4095];
  logic [3:0] act_r [0:4095];
  always @(posedge clk) begin
    #1;
    if (ncyc < 4095) ncyc = ncyc + 1;
    ser_r[ncyc] = ser;
    dn_r[ncyc]  = dn;
    act_r[ncyc] = act;
  end

  // Line level of bit j of a frame whose start bit begins at sample base; x if unstable.
  function automatic logic bit_at(input int d, input int base, input int j);
    int   s = base + j * CPB;
    logic v = ser_r[s][d];
    for (int i = 1; i < CPB; i++)
      if (ser_r[s + i][d] !== v) return 1'bx;
    return v;
  endfunction

  function automatic int done_cnt(input int d, input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++)
      if (dn_r[i][d] === 1'b1) n++;
    return n;
  endfunction

  task automatic push(input int d, input logic [7:0] b, output int mark);
    mark  = ncyc;
    dv[d] = 1'b1;
    by[d] = b;
    @(negedge clk);
    dv[d] = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (ser !== 4'hF) begin n_bad++; $display("FAIL reset_serial: got %b want 1111", ser); end
    n_cmp++; if (act !== 4'h0) begin n_bad++; $display("FAIL reset_active: got %b want 0000", act); end
    n_cmp++; if (dn !== 4'h0) begin n_bad++; $display("FAIL reset_done: got %b want 0000", dn); end
    n_cmp++; if (rdy !== 4'hF) begin n_bad++; $display("FAIL reset_ready: got %b want 1111", rdy); end
    n_cmp++; if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    int k;
    logic [9:0] exp = 10'h34A;
    push(0, 8'hA5, k);
    repeat (50) @(negedge clk);
    n_cmp++; if (ser_r[k+1][0] !== 1'b1) begin n_bad++; $display("FAIL 8n1_latency_high: got %b want 1", ser_r[k+1][0]); end
    n_cmp++; if (ser_r[k+2][0] !== 1'b0) begin n_bad++; $display("FAIL 8n1_latency_low: got %b want 0", ser_r[k+2][0]); end
    for (int j = 0; j < 10; j++) begin
      n_cmp++;
      if (bit_at(0, k+2, j) !== exp[j]) begin n_bad++; $display("FAIL 8n1_bit%0d: got %b want %b", j, bit_at(0, k+2, j), exp[j]); end
    end
    n_cmp++; if (done_cnt(0, k+1, k+50) !== 1) begin n_bad++; $display("FAIL 8n1_done_count: got %0d want 1", done_cnt(0, k+1, k+50)); end
    n_cmp++; if (dn_r[k+42][0] !== 1'b1) begin n_bad++; $display("FAIL 8n1_done_time: got %b want 1", dn_r[k+42][0]); end
    n_cmp++; if (act_r[k+41][0] !== 1'b1) begin n_bad++; $display("FAIL 8n1_active_end: got %b want 1", act_r[k+41][0]); end
    n_cmp++; if (act_r[k+42][0] !== 1'b0) begin n_bad++; $display("FAIL 8n1_active_after: got %b want 0", act_r[k+42][0]); end
    n_cmp++; if (ser_r[k+45][0] !== 1'b1) begin n_bad++; $display("FAIL 8n1_idle_line: got %b want 1", ser_r[k+45][0]); end
  endtask

  task automatic test_parity();
    int k;
    logic [10:0] exp_even = 11'h60E;
    logic [10:0] exp_odd  = 11'h40E;
    k = ncyc;
    dv[2:1] = 2'b11; by[1] = 8'h07; by[2] = 8'h07;
    @(negedge clk);
    dv[2:1] = 2'b00;
    repeat (55) @(negedge clk);
    for (int j = 0; j < 11; j++) begin
      n_cmp++;
      if (bit_at(1, k+2, j) !== exp_even[j]) begin n_bad++; $display("FAIL even_bit%0d: got %b want %b", j, bit_at(1, k+2, j), exp_even[j]); end
      n_cmp++;
      if (bit_at(2, k+2, j) !== exp_odd[j]) begin n_bad++; $display("FAIL odd_bit%0d: got %b want %b", j, bit_at(2, k+2, j), exp_odd[j]); end
    end
    n_cmp++; if (act_r[k+45][2:1] !== 2'b11) begin n_bad++; $display("FAIL parity_active_end: got %b want 11", act_r[k+45][2:1]); end
    n_cmp++; if (act_r[k+46][2:1] !== 2'b00) begin n_bad++; $display("FAIL parity_active_after: got %b want 00", act_r[k+46][2:1]); end
    n_cmp++; if (dn_r[k+46][2:1] !== 2'b11) begin n_bad++; $display("FAIL parity_done_time: got %b want 11", dn_r[k+46][2:1]); end
  endtask

  task automatic test_7bit_2stop();
    int k;
    logic [9:0] exp = 10'h3FE;
    push(3, 8'hFF, k);
    repeat (50) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      n_cmp++;
      if (bit_at(3, k+2, j) !== exp[j]) begin n_bad++; $display("FAIL 7n2_bit%0d: got %b want %b", j, bit_at(3, k+2, j), exp[j]); end
    end
    n_cmp++; if (act_r[k+41][3] !== 1'b1) begin n_bad++; $display("FAIL 7n2_active_end: got %b want 1", act_r[k+41][3]); end
    n_cmp++; if (act_r[k+42][3] !== 1'b0) begin n_bad++; $display("FAIL 7n2_active_after: got %b want 0", act_r[k+42][3]); end
    n_cmp++; if (dn_r[k+42][3] !== 1'b1) begin n_bad++; $display("FAIL 7n2_done_time: got %b want 1", dn_r[k+42][3]); end
    n_cmp++; if (done_cnt(3, k+1, k+50) !== 1) begin n_bad++; $display("FAIL 7n2_done_count: got %0d want 1", done_cnt(3, k+1, k+50)); end
  endtask

  task automatic test_back_to_back();
    int k;
    logic ok;
    logic [7:0] b [6] = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h55, 8'hEE};
    logic [9:0] exp;
    k = ncyc;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rdy[0] !== (i < 5)) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want %b", i, rdy[0], (i < 5)); end
      dv[0] = 1'b1; by[0] = b[i];
      @(negedge clk);
    end
    dv[0] = 1'b0;
    n_cmp++; if (cnt0 !== 3'd4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", cnt0); end
    repeat (205) @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      exp = {1'b1, b[f], 1'b0};
      for (int j = 0; j < 10; j++) begin
        n_cmp++;
        if (bit_at(0, k+2+40*f, j) !== exp[j]) begin n_bad++; $display("FAIL b2b_f%0d_bit%0d: got %b want %b", f, j, bit_at(0, k+2+40*f, j), exp[j]); end
      end
    end
    ok = 1'b1;
    for (int i = k+2; i <= k+201; i++) if (act_r[i][0] !== 1'b1) ok = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_active_held: got %b want 1", ok); end
    n_cmp++; if (act_r[k+202][0] !== 1'b0) begin n_bad++; $display("FAIL b2b_active_after: got %b want 0", act_r[k+202][0]); end
    n_cmp++; if (done_cnt(0, k+1, k+211) !== 5) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 5", done_cnt(0, k+1, k+211)); end
  endtask

  task automatic test_full_pop();
    int k;
    logic [7:0] b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [9:0] exp = {1'b1, 8'h96, 1'b0};
    k = ncyc;
    for (int i = 0; i < 5; i++) begin
      dv[0] = 1'b1; by[0] = b[i];
      @(negedge clk);
    end
    dv[0] = 1'b0;
    repeat (36) @(negedge clk);
    n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL full_ready_before: got %b want 0", rdy[0]); end
    n_cmp++; if (cnt0 !== 3'd4) begin n_bad++; $display("FAIL full_count_before: got %0d want 4", cnt0); end
    dv[0] = 1'b1; by[0] = 8'h96;
    @(negedge clk);
    n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL full_ready_after_pop: got %b want 1", rdy[0]); end
    n_cmp++; if (cnt0 !== 3'd3) begin n_bad++; $display("FAIL full_count_after_pop: got %0d want 3", cnt0); end
    @(negedge clk);
    dv[0] = 1'b0;
    n_cmp++; if (cnt0 !== 3'd4) begin n_bad++; $display("FAIL full_count_refill: got %0d want 4", cnt0); end
    n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL full_ready_refill: got %b want 0", rdy[0]); end
    repeat (205) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      n_cmp++;
      if (bit_at(0, k+202, j) !== exp[j]) begin n_bad++; $display("FAIL full_last_bit%0d: got %b want %b", j, bit_at(0, k+202, j), exp[j]); end
    end
    n_cmp++; if (act_r[k+242][0] !== 1'b0) begin n_bad++; $display("FAIL full_active_after: got %b want 0", act_r[k+242][0]); end
    n_cmp++; if (done_cnt(0, k+1, k+248) !== 6) begin n_bad++; $display("FAIL full_done_count: got %0d want 6", done_cnt(0, k+1, k+248)); end
  endtask

  task automatic test_reset_mid();
    int k, k2;
    logic ok;
    logic [9:0] exp = {1'b1, 8'h3C, 1'b0};
    k = ncyc;
    dv[0] = 1'b1; by[0] = 8'hA5; @(negedge clk);
    by[0] = 8'h11; @(negedge clk);
    by[0] = 8'h22; @(negedge clk);
    dv[0] = 1'b0;
    repeat (16) @(negedge clk);
    n_cmp++; if (act[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_active_before: got %b want 1", act[0]); end
    n_cmp++; if (ser[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_bit3_before: got %b want 0", ser[0]); end
    n_cmp++; if (cnt0 !== 3'd2) begin n_bad++; $display("FAIL rstmid_count_before: got %0d want 2", cnt0); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ser[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_serial: got %b want 1", ser[0]); end
    n_cmp++; if (act[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_active: got %b want 0", act[0]); end
    n_cmp++; if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", cnt0); end
    n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", rdy[0]); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k2 = ncyc;
    repeat (40) @(negedge clk);
    ok = 1'b1;
    for (int i = k2+1; i <= k2+40; i++) if (ser_r[i][0] !== 1'b1 || act_r[i][0] !== 1'b0) ok = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_queue_flushed: got %b want 1", ok); end
    n_cmp++; if (done_cnt(0, k+20, k2+40) !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt(0, k+20, k2+40)); end
    push(0, 8'h3C, k);
    repeat (50) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      n_cmp++;
      if (bit_at(0, k+2, j) !== exp[j]) begin n_bad++; $display("FAIL rstmid_clean_bit%0d: got %b want %b", j, bit_at(0, k+2, j), exp[j]); end
    end
    n_cmp++; if (done_cnt(0, k+1, k+50) !== 1) begin n_bad++; $display("FAIL rstmid_clean_done: got %0d want 1", done_cnt(0, k+1, k+50)); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) by[i] = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_7bit_2stop();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
